// File: rtl/vga_sync_gen_pkg.sv
// Shared raster-timing types and the default 640x480@60 timing set.
// Phase encoding and axis-total helper are shared by the generator and its axis counters.
package vga_sync_gen_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bus: pix_en in, sync/video/coordinate outputs back to the renderer.
interface vga_sync_gen_if #(
  parameter int CNT_W = 10
) ();
  logic             pix_en;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, video_on, pix_x, pix_y, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, video_on, pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/vga_sync_gen_sync_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// wrap flags the last count, qualified by wrap_en so the vertical axis reports end-of-frame only.
module sync_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             step,
  input  logic             wrap_en,
  output logic [CNT_W-1:0] count,
  output phase_e           phase,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;
  logic             terminal;

  assign terminal = (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step) begin
      count_d = terminal ? '0 : count_q + 1'b1;
      // Phase steps on the last count of each segment, so it always matches count_d.
      unique case (phase_q)
        PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == LAST_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = PH_BACK;
        PH_BACK:   if (terminal)               phase_d = PH_ACTIVE;
        default:                               phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!rst) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_q;
  assign phase = phase_q;
  assign wrap  = terminal & wrap_en;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: horizontal and vertical axis counters with registered output decode.
// Outputs describe the counter position from the previous enabled edge, all aligned together.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic          I_CLK,
  input  logic          rst,
  vga_sync_gen_if.master vif
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_e           h_phase, v_phase;
  logic             h_wrap, v_wrap;
  logic             pix_en;

  assign pix_en = vif.pix_en;

  sync_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .I_CLK   (I_CLK),
    .rst     (rst),
    .step    (pix_en),
    .wrap_en (1'b1),
    .count   (h_cnt),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  sync_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .I_CLK   (I_CLK),
    .rst     (rst),
    .step    (pix_en & h_wrap),
    .wrap_en (h_wrap),
    .count   (v_cnt),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  // origin_q marks that the counters sit at (0,0): set by reset and by the end-of-frame wrap.
  logic             origin_q, origin_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    origin_d      = origin_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = frame_start_q;
    if (pix_en) begin
      origin_d      = v_wrap;
      hsync_d       = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_d    = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      pix_x_d       = h_cnt;
      pix_y_d       = v_cnt;
      frame_start_d = origin_q;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!rst) begin
      origin_q      <= 1'b1;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      origin_q      <= origin_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.video_on    = video_on_q;
  assign vif.pix_x       = pix_x_q;
  assign vif.pix_y       = pix_y_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three builds (full timing, short frame, tiny) driven by shared stimulus,
// each compared every cycle against a position-arithmetic model, plus literal timing pins.
module tb_vga_sync_gen;

  logic I_CLK = 1'b0;
  logic rst;
  logic pix_en;
  int   tests = 0;
  int   fails = 0;

  always #5 I_CLK = ~I_CLK;

  vga_sync_gen_if #(.CNT_W(10)) a_if ();
  vga_sync_gen_if #(.CNT_W(10)) b_if ();
  vga_sync_gen_if #(.CNT_W(4))  c_if ();

  assign a_if.pix_en = pix_en;
  assign b_if.pix_en = pix_en;
  assign c_if.pix_en = pix_en;

  vga_sync_gen u_a (.I_CLK(I_CLK), .rst(rst), .vif(a_if.master));

  vga_sync_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (.I_CLK(I_CLK), .rst(rst), .vif(b_if.master));

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CNT_W(4)
  ) u_c (.I_CLK(I_CLK), .rst(rst), .vif(c_if.master));

  // Model state: number of enabled edges since the last reset edge.
  int n_model     = 0;
  bit model_valid = 1'b0;

  always @(posedge I_CLK) begin
    if (!rst) begin
      n_model     <= 0;
      model_valid <= 1'b1;
    end else if (pix_en) begin
      n_model <= n_model + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d", name, act, act, exp);
    end
  endtask

  // Expected outputs after n enabled edges: position n-1 in raster order, decoded by range tests.
  task automatic cmp(input string tag, input int n,
                     input int ha, input int hfp, input int hs, input int hb,
                     input int va, input int vfp, input int vs, input int vb,
                     input logic hsy, input logic vsy, input logic von, input logic fs,
                     input logic [31:0] x, input logic [31:0] y);
    int ht, vt, p, ex, ey;
    logic e_hs, e_vs, e_von, e_fs;
    ht = ha + hfp + hs + hb;
    vt = va + vfp + vs + vb;
    if (n == 0) begin
      ex = 0; ey = 0; e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0; e_fs = 1'b0;
    end else begin
      p     = n - 1;
      ex    = p % ht;
      ey    = (p / ht) % vt;
      e_hs  = !((ex >= ha + hfp) && (ex < ha + hfp + hs));
      e_vs  = !((ey >= va + vfp) && (ey < va + vfp + vs));
      e_von = (ex < ha) && (ey < va);
      e_fs  = (ex == 0) && (ey == 0);
    end
    chk({tag, "_pix_x"}, x, ex);
    chk({tag, "_pix_y"}, y, ey);
    chk({tag, "_hsync"}, {31'd0, hsy}, {31'd0, e_hs});
    chk({tag, "_vsync"}, {31'd0, vsy}, {31'd0, e_vs});
    chk({tag, "_video_on"}, {31'd0, von}, {31'd0, e_von});
    chk({tag, "_frame_start"}, {31'd0, fs}, {31'd0, e_fs});
  endtask

  always @(negedge I_CLK) begin
    if (model_valid) begin
      cmp("A", n_model, 640, 16, 96, 48, 480, 10, 2, 33,
          a_if.hsync, a_if.vsync, a_if.video_on, a_if.frame_start, 32'(a_if.pix_x), 32'(a_if.pix_y));
      cmp("B", n_model, 640, 16, 96, 48, 4, 1, 2, 1,
          b_if.hsync, b_if.vsync, b_if.video_on, b_if.frame_start, 32'(b_if.pix_x), 32'(b_if.pix_y));
      cmp("C", n_model, 4, 1, 2, 1, 3, 1, 1, 1,
          c_if.hsync, c_if.vsync, c_if.video_on, c_if.frame_start, 32'(c_if.pix_x), 32'(c_if.pix_y));
    end
  end

  task automatic tick(input logic r, input logic en);
    rst    = r;
    pix_en = en;
    @(posedge I_CLK);
    #1;
  endtask

  int hs_low, first_low, last_low, b_vs_low, c_fs_cnt, a_hs_en_low;

  initial begin
    rst    = 1'b0;
    pix_en = 1'b0;

    // Reset held for 5 cycles with arbitrary enable.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom_range(0, 1)));
    chk("rst_hsync", {31'd0, a_if.hsync}, 32'd1);
    chk("rst_vsync", {31'd0, a_if.vsync}, 32'd1);
    chk("rst_video_on", {31'd0, a_if.video_on}, 32'd0);
    chk("rst_pix_x", 32'(a_if.pix_x), 32'd0);
    chk("rst_frame_start", {31'd0, a_if.frame_start}, 32'd0);

    // First enabled edge presents the origin.
    tick(1'b1, 1'b1);
    chk("first_video_on", {31'd0, a_if.video_on}, 32'd1);
    chk("first_frame_start", {31'd0, a_if.frame_start}, 32'd1);
    chk("first_pix_y", 32'(a_if.pix_y), 32'd0);

    // Line 0 of the full-timing build with pinned boundaries.
    hs_low = 0; first_low = -1; last_low = -1; b_vs_low = 0;
    for (int n = 2; n <= 6401; n++) begin
      tick(1'b1, 1'b1);
      if (n <= 800 && a_if.hsync == 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(a_if.pix_x);
        last_low = int'(a_if.pix_x);
      end
      if (n <= 6400 && b_if.vsync == 1'b0) b_vs_low++;
      case (n)
        640:  chk("x639_video_on", {31'd0, a_if.video_on}, 32'd1);
        641:  chk("x640_video_on", {31'd0, a_if.video_on}, 32'd0);
        656:  chk("x655_hsync", {31'd0, a_if.hsync}, 32'd1);
        657:  chk("x656_hsync", {31'd0, a_if.hsync}, 32'd0);
        800:  chk("x799_pix_x", 32'(a_if.pix_x), 32'd799);
        801: begin
          chk("wrap_pix_x", 32'(a_if.pix_x), 32'd0);
          chk("wrap_pix_y", 32'(a_if.pix_y), 32'd1);
        end
        6400: chk("b_last_pix_y", 32'(b_if.pix_y), 32'd7);
        6401: begin
          chk("b_frame_pix_y", 32'(b_if.pix_y), 32'd0);
          chk("b_frame_start", {31'd0, b_if.frame_start}, 32'd1);
        end
        default: ;
      endcase
    end
    chk("hsync_width", 32'(hs_low), 32'd96);
    chk("hsync_first_x", 32'(first_low), 32'd656);
    chk("hsync_last_x", 32'(last_low), 32'd751);
    chk("b_vsync_width", 32'(b_vs_low), 32'd1600);

    // Alternating enable: one full line of A takes 1600 clocks, sync width counted in enabled cycles.
    a_hs_en_low = 0;
    for (int i = 0; i < 1600; i++) begin
      tick(1'b1, 1'(i % 2 == 0));
      if (i % 2 == 0 && a_if.hsync == 1'b0) a_hs_en_low++;
    end
    chk("gated_pix_x", 32'(a_if.pix_x), 32'd0);
    chk("gated_pix_y", 32'(a_if.pix_y), 32'd9);
    chk("gated_hsync_width", 32'(a_hs_en_low), 32'd96);

    // Random enable with rare resets; tiny build frame_start pulses counted on enabled cycles.
    c_fs_cnt = 0;
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4800; i++) begin
      tick(1'b1, 1'b1);
      if (c_if.frame_start) c_fs_cnt++;
    end
    chk("c_frame_count", 32'(c_fs_cnt), 32'd100);
    for (int i = 0; i < 20000; i++)
      tick(1'($urandom_range(0, 4999) != 0), 1'($urandom_range(0, 3) != 0));

    // Reset mid-line inside hsync abandons the line at once.
    tick(1'b0, 1'b0);
    for (int n = 1; n <= 1501; n++) tick(1'b1, 1'b1);
    chk("mid_pix_x", 32'(a_if.pix_x), 32'd700);
    chk("mid_hsync", {31'd0, a_if.hsync}, 32'd0);
    tick(1'b0, 1'b1);
    chk("mid_rst_hsync", {31'd0, a_if.hsync}, 32'd1);
    chk("mid_rst_pix_x", 32'(a_if.pix_x), 32'd0);
    tick(1'b1, 1'b1);
    chk("mid_rel_frame_start", {31'd0, a_if.frame_start}, 32'd1);
    chk("mid_rel_pix_y", 32'(a_if.pix_y), 32'd0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator for the game display.
- Downstream consumer of the clock divider: `I_CLK` is the divided pixel clock, 25 MHz for 640x480@60.
- Produces `hsync`/`vsync`, the active-video flag, the current pixel coordinates and a frame-start pulse.
- The renderer and game-logic blocks use these outputs to time per-frame physics and pixel colour lookup.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of `hsync`/`vsync` (0 = active-low)
- CNT_W, 10, width of counters and coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- I_CLK  in  1  pixel clock
- rst  in  1  reset, synchronous, active-low
- pix_en  in  1  advance enable; counters and outputs hold when low
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- video_on  out  1  high while position is inside the visible area
- pix_x  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- pix_y  out  CNT_W  current vertical position, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse when position (0,0) is presented

Behaviour:
- Interface fixed: clock I_CLK; reset rst, synchronous, active-low.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters h_cnt and v_cnt, each CNT_W bits, advance only on edges where rst=1 and pix_en=1.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. On the wrap, v_cnt increments.
- v_cnt wraps 0 after V_TOTAL-1; this happens only when h_cnt also wraps.
- Horizontal phase FSM follows h_cnt:
  - ACTIVE: h < H_ACTIVE
  - FRONT: H_ACTIVE ≤ h < H_ACTIVE+H_FP
  - SYNC: next H_SYNC counts
  - BACK: remainder
  - Transitions in order ACTIVE→FRONT→SYNC→BACK→ACTIVE, at the wrap.
- Vertical phase FSM is identical in form over v_cnt, but transitions only on h_cnt wrap.
- All outputs are registered decodes of the pre-advance counter/FSM state, so outputs lag the counters by exactly 1 enabled cycle. Within one cycle all outputs describe the same position.
- Output decode:
  - hsync = SYNC_POL while H-phase is SYNC, otherwise ~SYNC_POL.
  - vsync = SYNC_POL while V-phase is SYNC, otherwise ~SYNC_POL.
  - video_on = 1 only when both phases are ACTIVE.
  - frame_start = 1 for exactly one enabled cycle when the presented position is (0,0).
- pix_en=0: counters, FSMs and all outputs hold their value. frame_start also holds; consumers must qualify it with pix_en.
- Reset (rst=0 at an edge, regardless of pix_en):
  - h_cnt, v_cnt = 0; both FSMs = ACTIVE.
  - pix_x, pix_y = 0; video_on = 0; frame_start = 0.
  - hsync, vsync = ~SYNC_POL.
- After reset release, the first enabled edge presents (0,0): video_on=1, frame_start=1.
- Reset mid-frame immediately abandons the frame; no partial sync pulse is extended.
- No arithmetic overflow path: compare/wrap uses `==` against TOTAL-1, never counter overflow.

Decomposition:
- Shared package holds:
  - phase enum ACTIVE/FRONT/SYNC/BACK (2 bits)
  - default 640x480@60 timing constants
  - totals, as localparams derived from parameters
- One sub-module, `sync_axis_counter`: a generic counter+phase FSM with parameters ACTIVE/FP/SYNC/BP, inputs step and wrap-enable, outputs count, phase and wrap.
  - Instantiated twice: horizontal instance step=pix_en; vertical instance step=pix_en & h_wrap.

Test Plan:
- Reset check: hold rst=0 for 5 cycles → hsync=vsync=1, video_on=0, pix_x=pix_y=0, frame_start=0. Release with pix_en=1 → next cycle pix_x=0, pix_y=0, video_on=1, frame_start=1.
- Horizontal timing, pix_en=1:
  - video_on falls when pix_x reaches 640.
  - hsync low for exactly 96 cycles spanning pix_x=656..751.
  - pix_x wraps 799→0 and pix_y increments 0→1 the same cycle.
- Frame wrap: run 800×525 cycles → vsync low only for pix_y=490..491 (1600 cycles). After (799,524), output (0,0) with frame_start=1. frame_start count = 1 per frame.
- Enable gating: toggle pix_en 1/0 alternately over a full line → the line takes 1600 clocks, outputs hold on pix_en=0 cycles, and the hsync width equals 96 enabled cycles.
- Reset mid-frame: assert rst at pix_x=700, pix_y=300 (inside hsync) → hsync deasserts at the next edge, and the first enabled output after release is (0,0).
- Small-parameter build (H 4/1/2/1, V 3/1/1/1) → exhaustively compare all outputs against a reference model over 3 frames.
